// File: rtl/cnn_pkg.sv
// Shared constants, FSM state encoding and 8-bit quantization for the pool output writer.
// POOL_RELU_EN selects ReLU + unsigned clamp; otherwise signed saturation to -128..127.
package cnn_pkg;

    localparam int CNN_ADDRW = 12;
    localparam int CNN_DATAW = 16;
    localparam int CNN_ACCW  = 20;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } pow_state_t;

    // Clamp on the full-width value first, then keep the low byte.
    function automatic logic [7:0] quantize(input logic signed [31:0] v);
`ifdef POOL_RELU_EN
        if (v < 0)
            return 8'h00;
        else if (v > 127)
            return 8'h7F;
        else
            return v[7:0];
`else
        if (v < -128)
            return 8'h80;
        else if (v > 127)
            return 8'h7F;
        else
            return v[7:0];
`endif
    endfunction

endpackage

// File: rtl/pool_quantizer.sv
// Quantizes each accepted max-pool result into the q/q_valid/q_last pipeline register.
// Clamp behaviour follows POOL_RELU_EN through cnn_pkg::quantize.
module pool_quantizer
    import cnn_pkg::*;
#(
    parameter int ACCW = CNN_ACCW
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_accept,
    input  logic            i_valid,
    input  logic [ACCW-1:0] i_data,
    input  logic            i_last,
    output logic [7:0]      o_q,
    output logic            o_q_valid,
    output logic            o_q_last
);

    logic signed [31:0] w_ext;
    logic               w_take;
    logic [7:0]         r_q;
    logic               r_q_valid;
    logic               r_q_last;

    assign w_ext  = 32'($signed(i_data));
    assign w_take = i_valid && i_accept;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q       <= '0;
            r_q_valid <= 1'b0;
            r_q_last  <= 1'b0;
        end else begin
            r_q_valid <= w_take;
            r_q_last  <= w_take && i_last;
            if (w_take)
                r_q <= quantize(w_ext);
        end
    end

    assign o_q       = r_q;
    assign o_q_valid = r_q_valid;
    assign o_q_last  = r_q_last;

endmodule

// File: rtl/pool_output_writer.sv
// Packs quantized pool results into 16-bit words {second, first} and writes them to
// consecutive output SRAM addresses; flushes odd bytes and signals run completion.
module pool_output_writer
    import cnn_pkg::*;
#(
    parameter int ADDRW = CNN_ADDRW,
    parameter int DATAW = CNN_DATAW,
    parameter int ACCW  = CNN_ACCW
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             start,
    input  logic             pool_valid,
    input  logic [ACCW-1:0]  pool_data,
    input  logic             pool_last,
    input  logic             all_done,
    output logic             output_sram_write_enable,
    output logic [ADDRW-1:0] output_sram_write_addresss,
    output logic [DATAW-1:0] output_sram_write_data,
    output logic             busy,
    output logic             done
);

    pow_state_t       r_state;
    logic             r_pending;
    logic [7:0]       r_lo;
    logic [ADDRW-1:0] r_addr;
    logic             r_we;
    logic [ADDRW-1:0] r_wr_addr;
    logic [DATAW-1:0] r_wr_data;
    logic             r_busy;
    logic             r_done;

    logic             w_accept;
    logic [7:0]       w_q;
    logic             w_q_valid;
    logic             w_q_last;
    logic             w_active;
    logic             w_wr;
    logic [DATAW-1:0] w_word;

    // A start pulse also discards whatever result arrives in the same cycle.
    assign w_accept = (r_state == ST_RUN) && !start;
    assign w_active = ((r_state == ST_RUN) || (r_state == ST_FLUSH)) && !start;

    pool_quantizer #(
        .ACCW (ACCW)
    ) u_quant (
        .i_clk     (clk),
        .i_rst     (reset_b),
        .i_accept  (w_accept),
        .i_valid   (pool_valid),
        .i_data    (pool_data),
        .i_last    (pool_last),
        .o_q       (w_q),
        .o_q_valid (w_q_valid),
        .o_q_last  (w_q_last)
    );

    always_comb begin
        w_wr   = 1'b0;
        w_word = '0;
        if (w_active) begin
            if (w_q_valid) begin
                if (r_pending) begin
                    w_wr   = 1'b1;
                    w_word = DATAW'({w_q, r_lo});
                end else if (w_q_last) begin
                    w_wr   = 1'b1;
                    w_word = DATAW'({8'h00, w_q});
                end
            end else if ((r_state == ST_FLUSH) && r_pending) begin
                w_wr   = 1'b1;
                w_word = DATAW'({8'h00, r_lo});
            end
        end
    end

    always_ff @(posedge clk or posedge reset_b) begin
        if (reset_b) begin
            r_state   <= ST_IDLE;
            r_pending <= 1'b0;
            r_lo      <= '0;
            r_addr    <= '0;
            r_we      <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            if (w_wr) begin
                r_we      <= 1'b1;
                r_wr_addr <= r_addr;
                r_wr_data <= w_word;
                r_addr    <= r_addr + 1'b1;
            end
            if (start) begin
                r_state   <= ST_RUN;
                r_busy    <= 1'b1;
                r_pending <= 1'b0;
                r_addr    <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: ;
                    ST_RUN, ST_FLUSH: begin
                        if (w_q_valid) begin
                            if (r_pending) begin
                                r_pending <= 1'b0;
                            end else if (!w_q_last) begin
                                r_lo      <= w_q;
                                r_pending <= 1'b1;
                            end
                        end else if (r_state == ST_FLUSH) begin
                            r_pending <= 1'b0;
                            r_state   <= ST_DONE;
                        end
                        if ((r_state == ST_RUN) && all_done)
                            r_state <= ST_FLUSH;
                    end
                    ST_DONE: begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign output_sram_write_enable   = r_we;
    assign output_sram_write_addresss = r_wr_addr;
    assign output_sram_write_data     = r_wr_data;
    assign busy                       = r_busy;
    assign done                       = r_done;

endmodule

// File: tb/tb_pool_output_writer.sv
// Directed, table-driven bench for pool_output_writer; expected words are hand-computed
// for both POOL_RELU_EN settings.
module tb_pool_output_writer;

`ifdef POOL_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_b;
    logic        start;
    logic        pool_valid;
    logic [19:0] pool_data;
    logic        pool_last;
    logic        all_done;
    logic        output_sram_write_enable;
    logic [11:0] output_sram_write_addresss;
    logic [15:0] output_sram_write_data;
    logic        busy;
    logic        done;

    pool_output_writer dut (
        .clk                        (clk),
        .reset_b                    (reset_b),
        .start                      (start),
        .pool_valid                 (pool_valid),
        .pool_data                  (pool_data),
        .pool_last                  (pool_last),
        .all_done                   (all_done),
        .output_sram_write_enable   (output_sram_write_enable),
        .output_sram_write_addresss (output_sram_write_addresss),
        .output_sram_write_data     (output_sram_write_data),
        .busy                       (busy),
        .done                       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] addr;
        logic [15:0] data;
        time         t;
        logic        busy;
    } wr_t;

    typedef struct {
        int          a;
        int          b;
        logic [15:0] exp_sat;
        logic [15:0] exp_relu;
    } vec_t;

    wr_t  wq[$];
    int   done_cnt;
    time  done_t;
    logic done_busy;
    int   errors = 0;
    int   checks = 0;

    always @(negedge clk) begin
        if (output_sram_write_enable)
            wq.push_back('{output_sram_write_addresss, output_sram_write_data, $time, busy});
        if (done) begin
            done_cnt  = done_cnt + 1;
            done_t    = $time;
            done_busy = busy;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input int v, input logic last, output time t);
        @(negedge clk);
        pool_valid = 1'b1;
        pool_data  = v[19:0];
        pool_last  = last;
        t          = $time;
    endtask

    task automatic idle_in();
        @(negedge clk);
        pool_valid = 1'b0;
        pool_last  = 1'b0;
        pool_data  = '0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic clear_log();
        wq.delete();
        done_cnt = 0;
    endtask

    vec_t tbl[8];
    time  t0, t1, t2;

    initial begin
        tbl[0] = '{5,       300,     16'h7F05, 16'h7F05};
        tbl[1] = '{-7,      2,       16'h02F9, 16'h0200};
        tbl[2] = '{-500,    127,     16'h7F80, 16'h7F00};
        tbl[3] = '{128,     -128,    16'h807F, 16'h007F};
        tbl[4] = '{-129,    0,       16'h0080, 16'h0000};
        tbl[5] = '{524287,  -524288, 16'h807F, 16'h007F};
        tbl[6] = '{256,     -1,      16'hFF7F, 16'h007F};
        tbl[7] = '{100,     -256,    16'h8064, 16'h0064};

        reset_b    = 1'b1;
        start      = 1'b0;
        pool_valid = 1'b0;
        pool_data  = '0;
        pool_last  = 1'b0;
        all_done   = 1'b0;
        done_cnt   = 0;
        repeat (3) @(negedge clk);
        chk("reset_we",   32'(output_sram_write_enable), 0);
        chk("reset_addr", 32'(output_sram_write_addresss), 0);
        chk("reset_data", 32'(output_sram_write_data), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        reset_b = 1'b0;

        // Results while idle must be ignored.
        clear_log();
        send(5, 1'b0, t0);
        send(300, 1'b1, t0);
        send(9, 1'b1, t0);
        idle_in();
        repeat (4) @(negedge clk);
        chk("idle_writes", 32'(wq.size()), 0);
        chk("idle_busy",   32'(busy), 0);

        // Quantization table: one pair per entry, back-to-back.
        clear_log();
        pulse_start();
        chk("start_busy", 32'(busy), 1);
        foreach (tbl[i]) begin
            send(tbl[i].a, 1'b0, t0);
            send(tbl[i].b, 1'b1, t0);
        end
        idle_in();
        repeat (4) @(negedge clk);
        chk("tbl_count", 32'(wq.size()), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < wq.size()) begin
                chk($sformatf("tbl%0d_addr", i), 32'(wq[i].addr), 32'(i));
                chk($sformatf("tbl%0d_data", i), 32'(wq[i].data),
                    32'(RELU ? tbl[i].exp_relu : tbl[i].exp_sat));
            end
        end

        // 1,2,3 with last on 3: full word then half word on consecutive cycles.
        clear_log();
        pulse_start();
        send(1, 1'b0, t0);
        send(2, 1'b0, t1);
        send(3, 1'b1, t2);
        idle_in();
        repeat (4) @(negedge clk);
        chk("odd_count", 32'(wq.size()), 2);
        if (wq.size() == 2) begin
            chk("odd0_addr", 32'(wq[0].addr), 0);
            chk("odd0_data", 32'(wq[0].data), 32'h0201);
            chk("odd1_addr", 32'(wq[1].addr), 1);
            chk("odd1_data", 32'(wq[1].data), 32'h0003);
            chk("odd_latency", 32'(wq[0].t - t1), 20);
            chk("odd_consec",  32'(wq[1].t - wq[0].t), 10);
        end
        chk("odd_busy", 32'(busy), 1);

        // Pending byte flushed by all_done, then a single done pulse.
        clear_log();
        pulse_start();
        send(9, 1'b0, t0);
        @(negedge clk);
        pool_valid = 1'b0;
        all_done   = 1'b1;
        @(negedge clk);
        all_done   = 1'b0;
        for (int n = 0; n < 20 && done_cnt == 0; n++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("flush_count", 32'(wq.size()), 1);
        chk("flush_done_cnt", 32'(done_cnt), 1);
        if (wq.size() == 1) begin
            chk("flush_addr", 32'(wq[0].addr), 0);
            chk("flush_data", 32'(wq[0].data), 32'h0009);
            chk("flush_busy_at_wr", 32'(wq[0].busy), 1);
            chk("flush_done_after_wr", 32'(done_t - wq[0].t), 10);
        end
        chk("flush_busy_at_done", 32'(done_busy), 0);
        chk("flush_busy_end", 32'(busy), 0);

        // Flush with nothing pending: no write, still exactly one done.
        clear_log();
        pulse_start();
        @(negedge clk);
        all_done = 1'b1;
        @(negedge clk);
        all_done = 1'b0;
        for (int n = 0; n < 20 && done_cnt == 0; n++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("empty_writes", 32'(wq.size()), 0);
        chk("empty_done_cnt", 32'(done_cnt), 1);

        // Reset between the two bytes of a pair drops the pending byte.
        clear_log();
        pulse_start();
        send(11, 1'b0, t0);
        @(negedge clk);
        pool_valid = 1'b0;
        reset_b    = 1'b1;
        #1;
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_we",   32'(output_sram_write_enable), 0);
        @(negedge clk);
        reset_b = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_no_write", 32'(wq.size()), 0);
        pulse_start();
        send(3, 1'b0, t0);
        send(4, 1'b1, t0);
        idle_in();
        repeat (4) @(negedge clk);
        chk("rst_pair_count", 32'(wq.size()), 1);
        if (wq.size() == 1) begin
            chk("rst_pair_addr", 32'(wq[0].addr), 0);
            chk("rst_pair_data", 32'(wq[0].data), 32'h0403);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
